// File: rtl/prbs26_pkg.sv
// Shared types, widths and the next-state function of the 26-bit Galois PRBS
// (x^26+x^8+x^7+x+1). Bit 1 is the MSB, bit 26 the LSB.
package prbs26_pkg;
  localparam int PRBS_W = 26;
  localparam int TAP_A  = 1;
  localparam int TAP_B  = 7;
  localparam int TAP_C  = 8;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;

  function automatic logic [1:PRBS_W] prbs26_next(input logic [1:PRBS_W] s);
    logic [1:PRBS_W] n;
    if (s == '0) begin
      // zero-escape, mirrors the generator
      n = '0;
      n[PRBS_W] = 1'b1;
    end else begin
      n = {s[PRBS_W], s[1:PRBS_W-1]};
      n[TAP_A+1] = s[TAP_A] ^ s[PRBS_W];
      n[TAP_B+1] = s[TAP_B] ^ s[PRBS_W];
      n[TAP_C+1] = s[TAP_C] ^ s[PRBS_W];
    end
    return n;
  endfunction
endpackage

// File: rtl/prbs26_next_comb.sv
// Combinational PRBS26 predictor; lets both checker predictors share one implementation.
module prbs26_next_comb
  import prbs26_pkg::*;
(
  input  logic [1:PRBS_W] s_i,
  output logic [1:PRBS_W] n_o
);
  assign n_o = prbs26_next(s_i);
endmodule

// File: rtl/prbs26_checker.sv
// Self-synchronising PRBS26 stream checker: hunts, verifies, then flywheels on its
// own prediction while locked, reporting lock and a saturating mismatch count.
module prbs26_checker
  import prbs26_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [1:PRBS_W]  din,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int MAXC  = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int RUN_W = $clog2(MAXC + 1);

  state_e             state_q;
  logic [1:PRBS_W]    exp_q;
  logic [RUN_W-1:0]   run_q;
  logic               locked_q;
  logic               err_pulse_q;
  logic [ERR_W-1:0]   err_cnt_q;

  logic [1:PRBS_W]    nxt_din, nxt_exp;
  logic [RUN_W-1:0]   run_d;
  logic               match, miss_lk;

  prbs26_next_comb u_pred_din (.s_i(din),   .n_o(nxt_din));
  prbs26_next_comb u_pred_exp (.s_i(exp_q), .n_o(nxt_exp));

  assign run_d   = run_q + 1'b1;
  assign match   = (din == exp_q);
  assign miss_lk = din_valid && (state_q == LOCKED) && !match;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      exp_q       <= '0;
      run_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= miss_lk;
      // clear wins over the old value but still counts a coincident miss
      if (clr_err)
        err_cnt_q <= ERR_W'(miss_lk);
      else if (miss_lk && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + 1'b1;

      if (din_valid) begin
        case (state_q)
          HUNT: begin
            exp_q   <= nxt_din;
            run_q   <= '0;
            state_q <= VERIFY;
          end
          VERIFY: begin
            exp_q <= nxt_din;
            if (!match) begin
              run_q <= '0;
            end else if (run_d == RUN_W'(LOCK_CNT)) begin
              run_q    <= '0;
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              run_q <= run_d;
            end
          end
          LOCKED: begin
            exp_q <= nxt_exp;
            if (match) begin
              run_q <= '0;
            end else if (run_d == RUN_W'(LOSS_CNT)) begin
              run_q    <= '0;
              state_q  <= HUNT;
              locked_q <= 1'b0;
            end else begin
              run_q <= run_d;
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_prbs26_checker.sv
// Randomised bench for prbs26_checker against an arithmetic reference model.
module tb_prbs26_checker;
  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;
  localparam int ERR_W    = 4;
  localparam int CMAX     = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             din_valid = 1'b0;
  logic [25:0]      din = '0;
  logic             clr_err = 1'b0;
  logic             locked, err_pulse;
  logic [ERR_W-1:0] err_cnt;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int          m_mode;  // 0 hunt, 1 verify, 2 locked
  logic [25:0] m_exp;
  int          m_run;
  logic        m_locked, m_pulse;
  int          m_cnt;
  logic [25:0] gen;

  prbs26_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .clr_err(clr_err), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Galois step as a shift of the numeric value with the feedback mask applied
  // when the LSB falls out; all-zero escapes to 1.
  function automatic logic [25:0] ref_next(input logic [25:0] v);
    if (v == 26'd0) return 26'd1;
    return (v >> 1) ^ (v[0] ? 26'h3060000 : 26'h0);
  endfunction

  function automatic logic [25:0] good();
    logic [25:0] v;
    v = gen;
    gen = ref_next(gen);
    return v;
  endfunction

  task automatic model(input bit rst, input bit v, input logic [25:0] d, input bit clr);
    bit err;
    if (rst) begin
      m_mode = 0; m_exp = '0; m_run = 0; m_locked = 0; m_pulse = 0; m_cnt = 0;
      return;
    end
    err = v && (m_mode == 2) && (d != m_exp);
    m_pulse = err;
    if (clr) m_cnt = err ? 1 : 0;
    else if (err && m_cnt < CMAX) m_cnt++;
    if (v) begin
      if (m_mode == 0) begin
        m_exp = ref_next(d); m_run = 0; m_mode = 1;
      end else if (m_mode == 1) begin
        if (d == m_exp) begin
          m_run++;
          if (m_run == LOCK_CNT) begin m_run = 0; m_mode = 2; end
        end else m_run = 0;
        m_exp = ref_next(d);
      end else begin
        if (d == m_exp) m_run = 0;
        else begin
          m_run++;
          if (m_run == LOSS_CNT) begin m_run = 0; m_mode = 0; end
        end
        m_exp = ref_next(m_exp);
      end
    end
    m_locked = (m_mode == 2);
  endtask

  task automatic step(input bit rst, input bit v, input logic [25:0] d, input bit clr);
    @(negedge clk);
    rst_n = ~rst; din_valid = v; din = d; clr_err = clr;
    @(posedge clk);
    model(rst, v, d, clr);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, '0, 0);
    step(1, 1, 26'h1234567, 1);
    vectors++;
    if ({locked, err_pulse, err_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset: got lk=%b ep=%b cnt=%0d want all 0", locked, err_pulse, err_cnt);
    end
  endtask

  task automatic test_lock();
    gen = 26'h0000001;
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, good(), 0);
      vectors++;
      if ({locked, err_pulse, err_cnt} !== {m_locked, m_pulse, ERR_W'(m_cnt)} ||
          locked !== (i >= LOCK_CNT + 1) || err_pulse !== 1'b0) begin
        miscompares++;
        $display("FAIL lock[%0d]: got lk=%b ep=%b cnt=%0d want lk=%b ep=0 cnt=0",
                 i, locked, err_pulse, err_cnt, (i >= LOCK_CNT + 1));
      end
    end
  endtask

  task automatic test_flip();
    step(0, 1, good() ^ 26'h0000400, 0);
    vectors++;
    if (err_pulse !== 1'b1 || err_cnt !== ERR_W'(1) || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL flip: got ep=%b cnt=%0d lk=%b want ep=1 cnt=1 lk=1", err_pulse, err_cnt, locked);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, good(), 0);
      vectors++;
      if (err_pulse !== 1'b0 || err_cnt !== ERR_W'(1) || locked !== 1'b1) begin
        miscompares++;
        $display("FAIL flip_resume[%0d]: got ep=%b cnt=%0d lk=%b want ep=0 cnt=1 lk=1",
                 i, err_pulse, err_cnt, locked);
      end
    end
  endtask

  task automatic test_loss();
    for (int i = 1; i <= LOSS_CNT; i++) begin
      step(0, 1, good() ^ 26'h0000400, 0);
      vectors++;
      if (err_pulse !== 1'b1 || err_cnt !== ERR_W'(1 + i) || locked !== (i < LOSS_CNT)) begin
        miscompares++;
        $display("FAIL loss[%0d]: got ep=%b cnt=%0d lk=%b want ep=1 cnt=%0d lk=%b",
                 i, err_pulse, err_cnt, locked, 1 + i, (i < LOSS_CNT));
      end
    end
    for (int i = 1; i <= LOCK_CNT + 1; i++) begin
      step(0, 1, good(), 0);
      vectors++;
      if (locked !== (i == LOCK_CNT + 1) || err_pulse !== 1'b0 || err_cnt !== ERR_W'(1 + LOSS_CNT)) begin
        miscompares++;
        $display("FAIL relock[%0d]: got lk=%b ep=%b cnt=%0d want lk=%b ep=0 cnt=%0d",
                 i, locked, err_pulse, err_cnt, (i == LOCK_CNT + 1), 1 + LOSS_CNT);
      end
    end
  endtask

  task automatic test_gaps();
    int nv;
    step(1, 0, '0, 0);
    gen = 26'($urandom);
    nv = 0;
    while (nv < 20) begin
      repeat ($urandom_range(1, 5)) begin
        step(0, 0, 26'($urandom), 0);
        vectors++;
        if (locked !== (nv >= LOCK_CNT + 1) || err_pulse !== 1'b0 || err_cnt !== '0) begin
          miscompares++;
          $display("FAIL gap_bubble[%0d]: got lk=%b ep=%b cnt=%0d want lk=%b ep=0 cnt=0",
                   nv, locked, err_pulse, err_cnt, (nv >= LOCK_CNT + 1));
        end
      end
      step(0, 1, good(), 0);
      nv++;
      vectors++;
      if (locked !== (nv >= LOCK_CNT + 1) || err_pulse !== 1'b0 || err_cnt !== '0) begin
        miscompares++;
        $display("FAIL gap_valid[%0d]: got lk=%b ep=%b cnt=%0d want lk=%b ep=0 cnt=0",
                 nv, locked, err_pulse, err_cnt, (nv >= LOCK_CNT + 1));
      end
    end
  endtask

  task automatic test_sat();
    // 7 rounds of lose-lock (3 misses) then re-lock -> 21 errors
    for (int r = 0; r < 7; r++) begin
      repeat (LOSS_CNT) step(0, 1, good() ^ 26'(1 << $urandom_range(0, 25)), 0);
      repeat (LOCK_CNT + 1) step(0, 1, good(), 0);
    end
    vectors++;
    if (err_cnt !== ERR_W'(CMAX) || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL saturate: got cnt=%0d lk=%b want cnt=%0d lk=1", err_cnt, locked, CMAX);
    end
    step(0, 1, good() ^ 26'h0000400, 1);
    vectors++;
    if (err_cnt !== ERR_W'(1) || err_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_with_err: got cnt=%0d ep=%b want cnt=1 ep=1", err_cnt, err_pulse);
    end
    step(0, 1, good(), 1);
    vectors++;
    if (err_cnt !== '0 || err_pulse !== 1'b0 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_alone: got cnt=%0d ep=%b lk=%b want cnt=0 ep=0 lk=1", err_cnt, err_pulse, locked);
    end
  endtask

  task automatic test_zero();
    step(0, 1, good() ^ 26'h0000400, 0);
    step(1, 1, good(), 0);
    vectors++;
    if ({locked, err_pulse, err_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_midlock: got lk=%b ep=%b cnt=%0d want all 0", locked, err_pulse, err_cnt);
    end
    gen = 26'h0;
    for (int i = 1; i <= LOCK_CNT + 2; i++) begin
      step(0, 1, good(), 0);
      vectors++;
      if (locked !== (i >= LOCK_CNT + 1) || err_pulse !== 1'b0 || err_cnt !== '0) begin
        miscompares++;
        $display("FAIL zero_lock[%0d]: got lk=%b ep=%b cnt=%0d want lk=%b ep=0 cnt=0",
                 i, locked, err_pulse, err_cnt, (i >= LOCK_CNT + 1));
      end
    end
  endtask

  task automatic test_random();
    bit v, clr;
    logic [25:0] d;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) gen = 26'($urandom);
      v   = ($urandom_range(0, 99) < 80);
      clr = ($urandom_range(0, 99) < 3);
      d   = v ? good() : 26'($urandom);
      if (v && $urandom_range(0, 99) < 6) d ^= 26'(1 << $urandom_range(0, 25));
      step(0, v, d, clr);
      vectors++;
      if ({locked, err_pulse, err_cnt} !== {m_locked, m_pulse, ERR_W'(m_cnt)}) begin
        miscompares++;
        $display("FAIL random[%0d]: got lk=%b ep=%b cnt=%0d want lk=%b ep=%b cnt=%0d",
                 i, locked, err_pulse, err_cnt, m_locked, m_pulse, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_flip();
    test_loss();
    test_gaps();
    test_sat();
    test_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
